// File: rtl/uwasic_onboarding_harry_wang_pkg.sv
// Shared constants, config register bundle and PWM compare helper for the
// SPI-programmable 16-channel output/PWM controller.
package uwasic_onboarding_harry_wang_pkg;

    localparam int unsigned CLK_DIV  = 13;
    localparam int unsigned DIV_W    = $clog2(CLK_DIV);
    localparam logic [6:0]  MAX_ADDR = 7'd4;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    typedef struct packed {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  duty;
    } cfg_t;

    // Full-scale duty forces a solid high instead of 255/256.
    function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
        return (duty == 8'hFF) ? 1'b1 : (cnt < duty);
    endfunction

endpackage

// File: rtl/uwasic_onboarding_harry_wang_if.sv
// Tiny Tapeout user pin bundle; the tile drives the outputs, the harness the inputs.
interface uwasic_onboarding_harry_wang_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/uwasic_onboarding_harry_wang_spi_peripheral.sv
// Write-only SPI mode-0 peripheral: synchronizes the pins, shifts 16-bit frames
// and commits valid writes into the five config registers.
module uwasic_onboarding_harry_wang_spi_peripheral
    import uwasic_onboarding_harry_wang_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic copi,
    input  logic ncs,
    output cfg_t cfg
);

    logic [2:0]  sclk_q, copi_q, ncs_q;
    logic [15:0] shift_q;
    logic [4:0]  cnt_q;
    cfg_t        cfg_q, cfg_d;

    logic sclk_rise, ncs_fall, ncs_rise, commit;
    logic [6:0] addr;
    logic [7:0] data;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
    assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
    assign addr      = shift_q[14:8];
    assign data      = shift_q[7:0];
    assign commit    = ncs_rise && (cnt_q == 5'd16) && shift_q[15] && (addr <= MAX_ADDR);

    always_comb begin
        cfg_d = cfg_q;
        if (commit) begin
            case (addr)
                ADDR_EN_OUT_LO: cfg_d.en_out[7:0]  = data;
                ADDR_EN_OUT_HI: cfg_d.en_out[15:8] = data;
                ADDR_EN_PWM_LO: cfg_d.en_pwm[7:0]  = data;
                ADDR_EN_PWM_HI: cfg_d.en_pwm[15:8] = data;
                ADDR_DUTY:      cfg_d.duty         = data;
                default:        cfg_d              = cfg_q;
            endcase
        end
    end

    // nCS synchronizer resets high so releasing reset never fakes a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q  <= 3'b000;
            copi_q  <= 3'b000;
            ncs_q   <= 3'b111;
            shift_q <= '0;
            cnt_q   <= '0;
            cfg_q   <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            copi_q <= {copi_q[1:0], copi};
            ncs_q  <= {ncs_q[1:0], ncs};
            cfg_q  <= cfg_d;
            if (ncs_fall) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else if (sclk_rise && !ncs_q[1] && (cnt_q != 5'd16)) begin
                shift_q <= {shift_q[14:0], copi_q[1]};
                cnt_q   <= cnt_q + 5'd1;
            end
        end
    end

    assign cfg = cfg_q;

endmodule

// File: rtl/uwasic_onboarding_harry_wang.sv
// Tiny Tapeout top: SPI-configured 16-channel static/PWM output controller with a
// free-running ~3 kHz PWM timebase shared by all channels.
module uwasic_onboarding_harry_wang
    import uwasic_onboarding_harry_wang_pkg::*;
(
    input logic                           clk,
    input logic                           rst_n,
    uwasic_onboarding_harry_wang_if.slave tt
);

    cfg_t             cfg;
    logic [DIV_W-1:0] div_q;
    logic [7:0]       pwm_cnt_q;
    logic [15:0]      out_q, out_d;
    logic             pwm_sig;
    logic             unused;

    assign unused = &{1'b0, tt.ena, tt.uio_in, tt.ui_in[7:3]};

    uwasic_onboarding_harry_wang_spi_peripheral u_spi (
        .clk   (clk),
        .rst_n (rst_n),
        .sclk  (tt.ui_in[0]),
        .copi  (tt.ui_in[1]),
        .ncs   (tt.ui_in[2]),
        .cfg   (cfg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            pwm_cnt_q <= '0;
        end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_q     <= '0;
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign pwm_sig = pwm_level(pwm_cnt_q, cfg.duty);

    always_comb begin
        out_d = '0;
        for (int i = 0; i < 16; i++) begin
            out_d[i] = cfg.en_out[i] & (~cfg.en_pwm[i] | pwm_sig);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign tt.uo_out  = out_q[7:0];
    assign tt.uio_out = out_q[15:8];
    assign tt.uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_onboarding_harry_wang.sv
// Bench for the SPI output/PWM controller: frame table with scoreboard, PWM timing
// measurement and asynchronous reset mid-frame.
module tb_uwasic_onboarding_harry_wang;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    uwasic_onboarding_harry_wang_if tt ();

    uwasic_onboarding_harry_wang dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tt    (tt.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] word;
        int          nbits;
        logic [7:0]  exp_uo;
        logic [7:0]  exp_uio;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    vec_t vecs[15];
    exp_t sb[$];

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // SCLK = clk/16; bits past bit 0 of the word are sent as 1s.
    task automatic spi_frame(input logic [15:0] word, input int nbits);
        tt.ui_in[2] = 1'b0;
        clks(4);
        for (int i = 0; i < nbits; i++) begin
            tt.ui_in[1] = (i < 16) ? word[15-i] : 1'b1;
            clks(4);
            tt.ui_in[0] = 1'b1;
            clks(8);
            tt.ui_in[0] = 1'b0;
            clks(4);
        end
        tt.ui_in[2] = 1'b1;
        clks(2);
    endtask

    task automatic write_reg(input logic [6:0] addr, input logic [7:0] data);
        spi_frame({1'b1, addr, data}, 16);
        clks(6);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic prev, cur, found;
        int   high_cnt, period, ones, zeros;

        n_tests = 0;
        n_fail  = 0;
        vecs[0]  = '{"wr_out_lo_ff",     16'h80FF, 16, 8'hFF, 8'h00};
        vecs[1]  = '{"wr_out_hi_ff",     16'h81FF, 16, 8'hFF, 8'hFF};
        vecs[2]  = '{"read_frame",       16'h0000, 16, 8'hFF, 8'hFF};
        vecs[3]  = '{"wr_out_lo_a5",     16'h80A5, 16, 8'hA5, 8'hFF};
        vecs[4]  = '{"wr_out_hi_3c",     16'h813C, 16, 8'hA5, 8'h3C};
        vecs[5]  = '{"bad_addr_05",      16'h8500, 16, 8'hA5, 8'h3C};
        vecs[6]  = '{"bad_addr_7f",      16'hFF00, 16, 8'hA5, 8'h3C};
        vecs[7]  = '{"abort_10_bits",    16'h8000, 10, 8'hA5, 8'h3C};
        vecs[8]  = '{"wr_after_abort",   16'h8000, 16, 8'h00, 8'h3C};
        vecs[9]  = '{"frame_17_bits",    16'h80FF, 17, 8'hFF, 8'h3C};
        vecs[10] = '{"pwm_lo_duty0",     16'h82FE, 16, 8'h01, 8'h3C};
        vecs[11] = '{"duty_ff",          16'h84FF, 16, 8'hFF, 8'h3C};
        vecs[12] = '{"pwm_hi_duty_ff",   16'h83FF, 16, 8'hFF, 8'h3C};
        vecs[13] = '{"duty_00",          16'h8400, 16, 8'h01, 8'h00};
        vecs[14] = '{"read_duty",        16'h0481, 16, 8'h01, 8'h00};

        tt.ena    = 1'b1;
        tt.uio_in = 8'h00;
        tt.ui_in  = 8'b0000_0100;
        rst_n     = 1'b0;
        clks(3);
        check("reset_uo_out", {24'h0, tt.uo_out}, 32'h00);
        check("reset_uio_out", {24'h0, tt.uio_out}, 32'h00);
        check("reset_uio_oe", {24'h0, tt.uio_oe}, 32'hFF);
        rst_n = 1'b1;
        clks(4);

        for (int i = 0; i < 15; i++) begin
            spi_frame(vecs[i].word, vecs[i].nbits);
            sb.push_back('{vecs[i].name, vecs[i].exp_uo, vecs[i].exp_uio});
            clks(6);
            e = sb.pop_front();
            check({e.name, "_uo"}, {24'h0, tt.uo_out}, {24'h0, e.uo});
            check({e.name, "_uio"}, {24'h0, tt.uio_out}, {24'h0, e.uio});
        end

        // 50% PWM on channel 0 only: period 256*13 clk, high 128*13 clk.
        write_reg(7'h00, 8'hFF);
        write_reg(7'h01, 8'hFF);
        write_reg(7'h02, 8'h01);
        write_reg(7'h03, 8'h00);
        write_reg(7'h04, 8'h80);
        found = 1'b0;
        prev  = tt.uo_out[0];
        for (int i = 0; i < 10000; i++) begin
            clks(1);
            cur = tt.uo_out[0];
            if (!prev && cur) begin
                found = 1'b1;
                break;
            end
            prev = cur;
        end
        check("pwm_first_rise", {31'h0, found}, 32'h1);
        check("pwm_static_bits", {25'h0, tt.uo_out[7:1]}, 32'h7F);
        check("pwm_uio_static", {24'h0, tt.uio_out}, 32'hFF);
        high_cnt = 1;
        period   = 1;
        found    = 1'b0;
        prev     = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            clks(1);
            cur = tt.uo_out[0];
            if (!prev && cur) begin
                found = 1'b1;
                break;
            end
            period++;
            if (cur) high_cnt++;
            prev = cur;
        end
        check("pwm_second_rise", {31'h0, found}, 32'h1);
        check_range("pwm_period_clks", period, 3295, 3361);
        check_range("pwm_high_clks", high_cnt, 1651, 1677);

        write_reg(7'h04, 8'h00);
        ones = 0;
        for (int i = 0; i < 3400; i++) begin
            clks(1);
            if (tt.uo_out[0]) ones++;
        end
        check("duty00_high_samples", ones, 0);

        write_reg(7'h04, 8'hFF);
        zeros = 0;
        for (int i = 0; i < 3400; i++) begin
            clks(1);
            if (!tt.uo_out[0]) zeros++;
        end
        check("dutyff_low_samples", zeros, 0);
        check("pre_reset_uo", {24'h0, tt.uo_out}, 32'hFF);

        // Reset mid-frame while PWM runs: outputs drop without waiting for a clock.
        tt.ui_in[2] = 1'b0;
        clks(4);
        for (int i = 0; i < 5; i++) begin
            tt.ui_in[1] = 1'b1;
            clks(4);
            tt.ui_in[0] = 1'b1;
            clks(8);
            tt.ui_in[0] = 1'b0;
            clks(4);
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_uo", {24'h0, tt.uo_out}, 32'h00);
        check("async_reset_uio", {24'h0, tt.uio_out}, 32'h00);
        tt.ui_in = 8'b0000_0100;
        clks(3);
        rst_n = 1'b1;
        clks(4);
        write_reg(7'h00, 8'h81);
        check("post_reset_write_uo", {24'h0, tt.uo_out}, 32'h81);
        check("post_reset_write_uio", {24'h0, tt.uio_out}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
